id_stage_ctrl: RTL

//  Decode-stage controller between fetch and execute. Accepts (pc, instr) on a valid/ready handshake and

---
 rtl/rv_isa_pkg.sv | 34 +++
 rtl/id_stage_ctrl_if.sv | 35 +++
 rtl/id_stage_ctrl_imm_gen.sv | 29 ++
 rtl/id_stage_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/rv_isa_pkg.sv
// Shared RV32I decode definitions: opcode constants, instruction format
// codes and the occupancy encoding of the decode-stage skid buffer.
package rv_isa_pkg;

  // RV32I base opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Instruction format codes carried with each decoded entry
  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  // Skid-buffer occupancy: value equals the number of held entries
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/id_stage_ctrl_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1. The sender keeps valid and its payload
// stable until that edge; ready may be raised or lowered freely, and valid
// never depends on ready. flush squashes everything buffered in the stage.
//
// modport slave  : the decode stage itself
// modport master : its environment (fetch drives in_*, execute drives out_ready)
interface id_stage_ctrl_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic [31:0]     out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/id_stage_ctrl_imm_gen.sv
// Combinational RV32I immediate generator. Sign bit is always instr[31];
// FENCE/SYSTEM/R-type and unknown opcodes give 0.
module id_stage_ctrl_imm_gen
  import rv_isa_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  // Select the bit layout for the opcode
  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {instr[31:12], 12'h000};
      OPC_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: decodes (pc, instr) at the input and holds the
// result in a 2-entry skid buffer (output reg + skid reg), so every output
// is registered and in_ready depends only on the state register.
// Optional feature: define ID_ILLEGAL_CHK_EN to flag non-RV32I opcodes on
// out_illegal; otherwise out_illegal is tied 0.
module id_stage_ctrl
  import rv_isa_pkg::*;
#(
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  id_stage_ctrl_if.slave    bus,
  output state_t            state_dbg
);

  // Opcode to format code; anything outside the base set is FMT_NONE
  function automatic logic [2:0] decode_fmt(input logic [6:0] opc);
    case (opc)
      OPC_OP:                                     return FMT_R;
      OPC_LOAD, OPC_OP_IMM, OPC_JALR,
      OPC_MISC_MEM, OPC_SYSTEM:                   return FMT_I;
      OPC_STORE:                                  return FMT_S;
      OPC_BRANCH:                                 return FMT_B;
      OPC_LUI, OPC_AUIPC:                         return FMT_U;
      OPC_JAL:                                    return FMT_J;
      default:                                    return FMT_NONE;
    endcase
  endfunction

  state_t          state;
  logic [31:0]     in_imm;
  logic [2:0]      in_fmt;
  logic            in_fire;
  logic            out_fire;
  logic            ld_out_in;
  logic            ld_out_skid;
  logic            ld_skid;

  logic [31:0]     out_instr_q, skid_instr_q;
  logic [PC_W-1:0] out_pc_q,    skid_pc_q;
  logic [31:0]     out_imm_q,   skid_imm_q;
  logic [2:0]      out_fmt_q,   skid_fmt_q;

  id_stage_ctrl_imm_gen u_imm_gen (
    .instr (bus.in_instr),
    .imm   (in_imm)
  );

  assign in_fmt = decode_fmt(bus.in_instr[6:0]);

  assign bus.in_ready  = (state != ST_FULL);
  assign bus.out_valid = (state != ST_EMPTY);
  assign in_fire       = bus.in_valid  & bus.in_ready;
  assign out_fire      = bus.out_valid & bus.out_ready;

  // Data-register load enables; flush blocks every load so nothing moves
  assign ld_out_in   = ~bus.flush & in_fire &
                       ((state == ST_EMPTY) | ((state == ST_HALF) & out_fire));
  assign ld_skid     = ~bus.flush & in_fire & (state == ST_HALF) & ~out_fire;
  assign ld_out_skid = ~bus.flush & (state == ST_FULL) & out_fire;

  // Occupancy FSM; flush overrides any same-cycle transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else if (bus.flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_fire) state <= ST_HALF;
        ST_HALF: begin
          if (in_fire && !out_fire)      state <= ST_FULL;
          else if (!in_fire && out_fire) state <= ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state <= ST_HALF;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  // Output and skid data registers; they only change on a load enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_instr_q  <= NOP_INSTR;
      out_pc_q     <= '0;
      out_imm_q    <= '0;
      out_fmt_q    <= FMT_I;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= '0;
    end else begin
      if (ld_out_in) begin
        out_instr_q <= bus.in_instr;
        out_pc_q    <= bus.in_pc;
        out_imm_q   <= in_imm;
        out_fmt_q   <= in_fmt;
      end else if (ld_out_skid) begin
        out_instr_q <= skid_instr_q;
        out_pc_q    <= skid_pc_q;
        out_imm_q   <= skid_imm_q;
        out_fmt_q   <= skid_fmt_q;
      end
      if (ld_skid) begin
        skid_instr_q <= bus.in_instr;
        skid_pc_q    <= bus.in_pc;
        skid_imm_q   <= in_imm;
        skid_fmt_q   <= in_fmt;
      end
    end
  end

`ifdef ID_ILLEGAL_CHK_EN
  logic in_illegal;
  logic out_illegal_q, skid_illegal_q;

  // Non-32-bit encodings and unknown opcodes are illegal in the base set
  assign in_illegal = (bus.in_instr[1:0] != 2'b11) | (in_fmt == FMT_NONE);

  // Illegal flag travels with its entry through the skid buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_illegal_q  <= 1'b0;
      skid_illegal_q <= 1'b0;
    end else begin
      if (ld_out_in)        out_illegal_q <= in_illegal;
      else if (ld_out_skid) out_illegal_q <= skid_illegal_q;
      if (ld_skid)          skid_illegal_q <= in_illegal;
    end
  end

  assign bus.out_illegal = out_illegal_q;
`else
  assign bus.out_illegal = 1'b0;
`endif

  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_fmt   = out_fmt_q;
  assign state_dbg     = state;

endmodule
